// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - pushbutton time-setting front end for the 12/24-hour clock
//
// Purpose: debounces mode/inc/dec buttons, runs the RUN -> SET_HR -> SET_MIN -> COMMIT
// edit FSM, holds the edited hour/minute and drives the clock's load interface.
//
// Ports:
//   clk_i        in   system clock
//   nReset_i     in   asynchronous active-low reset
//   btn_mode_i   in   raw mode button (active high, asynchronous)
//   btn_inc_i    in   raw increment button (active high, asynchronous)
//   btn_dec_i    in   raw decrement button (active high, asynchronous)
//   Lhourhigh_o  out  hour tens digit, BCD
//   Lhourlow_o   out  hour units digit, BCD
//   Lminhigh_o   out  minute tens digit, BCD
//   Lminlow_o    out  minute units digit, BCD
//   nLoad_o      out  active-low load strobe, low for the single COMMIT cycle
//   loadOrNah_o  out  load enable, high for the single COMMIT cycle
//   editing_o    out  high in SET_HR or SET_MIN
//   blink_hr_o   out  blank hour digits (blink phase in SET_HR)
//   blink_min_o  out  blank minute digits (blink phase in SET_MIN)
module time_set_ctrl #(
  parameter int DEBOUNCE_CNT = 499999,
  parameter int BLINK_CNT    = 24999999,
  parameter int HR_MAX       = 11,
  parameter int MIN_MAX      = 59,
  parameter int ZEROZ        = 1
) (
  input  logic       clk_i,
  input  logic       nReset_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_dec_i,
  output logic [3:0] Lhourhigh_o,
  output logic [3:0] Lhourlow_o,
  output logic [3:0] Lminhigh_o,
  output logic [3:0] Lminlow_o,
  output logic       nLoad_o,
  output logic       loadOrNah_o,
  output logic       editing_o,
  output logic       blink_hr_o,
  output logic       blink_min_o
);

  localparam int         DW     = $clog2(DEBOUNCE_CNT + 2);
  localparam int         BW     = $clog2(BLINK_CNT + 2);
  localparam logic [6:0] HR_LO  = (ZEROZ != 0) ? 7'd1 : 7'd0;
  localparam logic [6:0] HR_HI  = (ZEROZ != 0) ? 7'(HR_MAX + 1) : 7'(HR_MAX);
  localparam logic [6:0] HR_RST = (ZEROZ != 0) ? HR_HI : 7'd0;
  localparam logic [6:0] MIN_HI = 7'(MIN_MAX);

  typedef enum logic [1:0] {S_RUN, S_SET_HR, S_SET_MIN, S_COMMIT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q, db_q, db_d, db_prev_q, press_q;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];
  logic [6:0]    hour_q, hour_d, min_q, min_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          mode_ev, inc_ev, dec_ev, adj_ev, edit_st;

  // bit 0 = mode, bit 1 = inc, bit 2 = dec
  assign raw = {btn_dec_i, btn_inc_i, btn_mode_i};

  // A differing synced level must persist DEBOUNCE_CNT+1 cycles; any return to the
  // accepted level restarts the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]   = db_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CNT)) db_d[i] = sync2_q[i];
        else                                dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Mode wins over inc/dec; simultaneous inc and dec cancel each other.
  assign mode_ev = press_q[0];
  assign inc_ev  = press_q[1] & ~press_q[2] & ~mode_ev;
  assign dec_ev  = press_q[2] & ~press_q[1] & ~mode_ev;
  assign edit_st = (state_q == S_SET_HR) || (state_q == S_SET_MIN);
  assign adj_ev  = (inc_ev | dec_ev) & edit_st;

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) state_q <= S_RUN;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:     if (mode_ev) state_d = S_SET_HR;
      S_SET_HR:  if (mode_ev) state_d = S_SET_MIN;
      S_SET_MIN: if (mode_ev) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  always_comb begin
    editing_o   = edit_st;
    nLoad_o     = (state_q != S_COMMIT);
    loadOrNah_o = (state_q == S_COMMIT);
    blink_hr_o  = phase_q & (state_q == S_SET_HR);
    blink_min_o = phase_q & (state_q == S_SET_MIN);
  end

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    if (state_q == S_SET_HR) begin
      if (inc_ev)      hour_d = (hour_q == HR_HI) ? HR_LO : hour_q + 7'd1;
      else if (dec_ev) hour_d = (hour_q == HR_LO) ? HR_HI : hour_q - 7'd1;
    end else if (state_q == S_SET_MIN) begin
      if (inc_ev)      min_d = (min_q == MIN_HI) ? 7'd0 : min_q + 7'd1;
      else if (dec_ev) min_d = (min_q == 7'd0) ? MIN_HI : min_q - 7'd1;
    end
  end

  // Blink restarts on any state change or edit so the edited digits show at once.
  always_comb begin
    bcnt_d  = '0;
    phase_d = 1'b0;
    if (edit_st && (state_d == state_q) && !adj_ev) begin
      if (bcnt_q == BW'(BLINK_CNT)) begin
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      hour_q  <= HR_RST;
      min_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      hour_q  <= hour_d;
      min_q   <= min_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Values never exceed 99, so tens is the largest k with 10*k <= v.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    tens = '0;
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(10 * k)) tens = 4'(k);
    end
    return {tens, 4'(v - 7'(10 * tens))};
  endfunction

  assign {Lhourhigh_o, Lhourlow_o} = to_bcd(hour_q);
  assign {Lminhigh_o, Lminlow_o}   = to_bcd(min_q);

endmodule
